// File: rtl/pcie_cpl_rx_axi_r.sv
// Completion receive path: maps completion TLP tags back to AXI ARIDs through a
// tag table and streams the payload onto the AXI4 R channel.
module pcie_cpl_rx_axi_r #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned CHUNK_MAX_BEATS = 4,
    parameter int unsigned NUM_TAGS        = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  tag_alloc_valid,
    input  logic [$clog2(NUM_TAGS)-1:0]           tag_alloc_tag,
    input  logic [ID_WIDTH-1:0]                   tag_alloc_id,
    input  logic [8:0]                            tag_alloc_beats,
    output logic [NUM_TAGS-1:0]                   tag_busy,
    input  logic                                  cpl_valid,
    output logic                                  cpl_ready,
    input  logic [7:0]                            cpl_tag,
    input  logic [2:0]                            cpl_status,
    input  logic [9:0]                            cpl_length,
    input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] cpl_data,
    output logic                                  rvalid,
    input  logic                                  rready,
    output logic [ID_WIDTH-1:0]                   rid,
    output logic [DATA_WIDTH-1:0]                 rdata,
    output logic [1:0]                            rresp,
    output logic                                  rlast,
    output logic                                  err_unexp_cpl,
    output logic                                  err_tag_busy
);
    localparam int unsigned TAG_W  = $clog2(NUM_TAGS);
    localparam int unsigned K_W    = (CHUNK_MAX_BEATS > 1) ? $clog2(CHUNK_MAX_BEATS) : 1;
    localparam int unsigned MAX_DW = 8 * CHUNK_MAX_BEATS;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state;
    logic [ID_WIDTH-1:0]     entry_id  [NUM_TAGS];
    logic [8:0]              entry_rem [NUM_TAGS];
    logic [DATA_WIDTH-1:0]   payload   [CHUNK_MAX_BEATS];
    logic [TAG_W-1:0]        cur_tag;
    logic [8:0]              beats_left;
    logic [K_W-1:0]          beat_idx;
    logic                    cur_err;

    logic [TAG_W-1:0]        cpl_idx;
    logic                    cpl_sc;
    logic                    cpl_unexp;
    logic [8:0]              chunk_beats;
    logic [8:0]              first_n;
    logic [8:0]              cur_rem;
    logic [K_W-1:0]          next_idx;
    logic                    xfer;

    // Completion classification and beat-count arithmetic
    always_comb begin
        cpl_idx     = cpl_tag[TAG_W-1:0];
        cpl_sc      = (cpl_status == 3'b000);
        cpl_unexp   = (32'(cpl_tag) >= NUM_TAGS) || !tag_busy[cpl_idx] ||
                      (cpl_sc && ((cpl_length == 10'd0) || (32'(cpl_length) > MAX_DW)));
        chunk_beats = 9'((11'(cpl_length) + 11'd7) >> 3);
        first_n     = (!cpl_sc || (entry_rem[cpl_idx] < chunk_beats)) ?
                      entry_rem[cpl_idx] : chunk_beats;
        cur_rem     = entry_rem[cur_tag];
        next_idx    = beat_idx + K_W'(1);
        xfer        = rvalid && rready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            tag_busy      <= '0;
            cpl_ready     <= 1'b1;
            rvalid        <= 1'b0;
            rlast         <= 1'b0;
            rid           <= '0;
            rdata         <= '0;
            rresp         <= 2'b00;
            err_unexp_cpl <= 1'b0;
            err_tag_busy  <= 1'b0;
            cur_tag       <= '0;
            beats_left    <= '0;
            beat_idx      <= '0;
            cur_err       <= 1'b0;
        end else begin
            err_unexp_cpl <= 1'b0;
            err_tag_busy  <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpl_valid && cpl_ready) begin
                        if (cpl_unexp) begin
                            err_unexp_cpl <= 1'b1;
                        end else begin
                            for (int k = 0; k < CHUNK_MAX_BEATS; k++)
                                payload[k] <= cpl_data[k*DATA_WIDTH +: DATA_WIDTH];
                            cur_tag    <= cpl_idx;
                            beats_left <= first_n;
                            beat_idx   <= '0;
                            cur_err    <= !cpl_sc;
                            rid        <= entry_id[cpl_idx];
                            rdata      <= cpl_sc ? cpl_data[DATA_WIDTH-1:0] : '0;
                            rresp      <= cpl_sc ? 2'b00 : 2'b10;
                            rlast      <= (entry_rem[cpl_idx] == 9'd1);
                            rvalid     <= 1'b1;
                            cpl_ready  <= 1'b0;
                            state      <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        entry_rem[cur_tag] <= cur_rem - 9'd1;
                        beats_left         <= beats_left - 9'd1;
                        beat_idx           <= next_idx;
                        if (beats_left == 9'd1) begin
                            state     <= IDLE;
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            cpl_ready <= 1'b1;
                            if (cur_rem == 9'd1)
                                tag_busy[cur_tag] <= 1'b0;
                        end else begin
                            rdata <= cur_err ? '0 : payload[next_idx];
                            rlast <= (cur_rem == 9'd2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Allocation checks the pre-update valid bit, so a same-cycle free still rejects
            if (tag_alloc_valid) begin
                if (tag_busy[tag_alloc_tag]) begin
                    err_tag_busy <= 1'b1;
                end else begin
                    tag_busy[tag_alloc_tag]  <= 1'b1;
                    entry_id[tag_alloc_tag]  <= tag_alloc_id;
                    entry_rem[tag_alloc_tag] <= tag_alloc_beats;
                end
            end
        end
    end
endmodule

// File: tb/tb_pcie_cpl_rx_axi_r.sv
// Directed bench for the completion receive path: single, split, backpressured,
// error-status, unexpected/busy and mid-stream reset scenarios.
module tb_pcie_cpl_rx_axi_r;
    logic          clk;
    logic          rst_n;
    logic          tag_alloc_valid;
    logic [3:0]    tag_alloc_tag;
    logic [3:0]    tag_alloc_id;
    logic [8:0]    tag_alloc_beats;
    logic [15:0]   tag_busy;
    logic          cpl_valid;
    logic          cpl_ready;
    logic [7:0]    cpl_tag;
    logic [2:0]    cpl_status;
    logic [9:0]    cpl_length;
    logic [1023:0] cpl_data;
    logic          rvalid;
    logic          rready;
    logic [3:0]    rid;
    logic [255:0]  rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          err_unexp_cpl;
    logic          err_tag_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] got_data [$];
    logic [3:0]   got_id   [$];
    logic [1:0]   got_resp [$];
    logic         got_last [$];

    pcie_cpl_rx_axi_r dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tag_alloc_valid (tag_alloc_valid),
        .tag_alloc_tag   (tag_alloc_tag),
        .tag_alloc_id    (tag_alloc_id),
        .tag_alloc_beats (tag_alloc_beats),
        .tag_busy        (tag_busy),
        .cpl_valid       (cpl_valid),
        .cpl_ready       (cpl_ready),
        .cpl_tag         (cpl_tag),
        .cpl_status      (cpl_status),
        .cpl_length      (cpl_length),
        .cpl_data        (cpl_data),
        .rvalid          (rvalid),
        .rready          (rready),
        .rid             (rid),
        .rdata           (rdata),
        .rresp           (rresp),
        .rlast           (rlast),
        .err_unexp_cpl   (err_unexp_cpl),
        .err_tag_busy    (err_tag_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        got_data.delete();
        got_id.delete();
        got_resp.delete();
        got_last.delete();
    endtask

    task automatic alloc(input logic [3:0] tag, input logic [3:0] id, input logic [8:0] beats);
        tag_alloc_valid = 1'b1;
        tag_alloc_tag   = tag;
        tag_alloc_id    = id;
        tag_alloc_beats = beats;
        @(negedge clk);
        tag_alloc_valid = 1'b0;
    endtask

    task automatic send_cpl(input logic [7:0] tag, input logic [2:0] st,
                            input logic [9:0] len, input logic [7:0] base);
        int cyc = 0;
        while (!cpl_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("cpl_ready_wait", 256'(cpl_ready), 256'(1));
        cpl_valid  = 1'b1;
        cpl_tag    = tag;
        cpl_status = st;
        cpl_length = len;
        for (int k = 0; k < 4; k++)
            cpl_data[k*256 +: 256] = 256'(base + 8'(k));
        @(negedge clk);
        cpl_valid = 1'b0;
    endtask

    // Collects R beats until the queue holds target entries; optional stall pattern
    task automatic drain(input int target, input bit use_pat);
        bit [6:0]     pat = 7'b1101001;
        int           cyc = 0;
        int           pidx = 0;
        bit           stalled = 1'b0;
        logic [255:0] h_data = '0;
        logic [3:0]   h_id = '0;
        logic [1:0]   h_resp = '0;
        logic         h_last = 1'b0;
        while (got_data.size() < target && cyc < 100) begin
            if (stalled) begin
                check("stall_valid", 256'(rvalid), 256'(1));
                check("stall_data", rdata, h_data);
                check("stall_id", 256'(rid), 256'(h_id));
                check("stall_resp", 256'(rresp), 256'(h_resp));
                check("stall_last", 256'(rlast), 256'(h_last));
            end
            if (rvalid) begin
                rready = use_pat ? pat[pidx % 7] : 1'b1;
                pidx++;
            end else begin
                rready = 1'b0;
            end
            stalled = rvalid && !rready;
            h_data = rdata;
            h_id   = rid;
            h_resp = rresp;
            h_last = rlast;
            if (rvalid && rready) begin
                got_data.push_back(rdata);
                got_id.push_back(rid);
                got_resp.push_back(rresp);
                got_last.push_back(rlast);
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        check("drain_count", 256'(got_data.size()), 256'(target));
    endtask

    task automatic verify(input int i, input logic [255:0] edata, input logic [3:0] eid,
                          input logic [1:0] eresp, input logic elast);
        if (i < got_data.size()) begin
            check($sformatf("beat%0d_data", i), got_data[i], edata);
            check($sformatf("beat%0d_id", i), 256'(got_id[i]), 256'(eid));
            check($sformatf("beat%0d_resp", i), 256'(got_resp[i]), 256'(eresp));
            check($sformatf("beat%0d_last", i), 256'(got_last[i]), 256'(elast));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        tag_alloc_valid = 1'b0;
        tag_alloc_tag   = '0;
        tag_alloc_id    = '0;
        tag_alloc_beats = '0;
        cpl_valid       = 1'b0;
        cpl_tag         = '0;
        cpl_status      = '0;
        cpl_length      = '0;
        cpl_data        = '0;
        rready          = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_rvalid", 256'(rvalid), 256'(0));
        check("rst_rlast", 256'(rlast), 256'(0));
        check("rst_tag_busy", 256'(tag_busy), 256'(0));
        check("rst_cpl_ready", 256'(cpl_ready), 256'(1));
        check("rst_rid", 256'(rid), 256'(0));
        check("rst_rdata", rdata, 256'(0));
        check("rst_rresp", 256'(rresp), 256'(0));
        check("rst_err_unexp", 256'(err_unexp_cpl), 256'(0));
        check("rst_err_busy", 256'(err_tag_busy), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single completion covering the whole burst
        alloc(4'd3, 4'd5, 9'd4);
        check("single_busy_set", 256'(tag_busy), 256'(16'h0008));
        clear_q();
        send_cpl(8'd3, 3'b000, 10'd32, 8'hA0);
        drain(4, 1'b0);
        for (int i = 0; i < 4; i++)
            verify(i, 256'(8'hA0 + 8'(i)), 4'd5, 2'b00, i == 3);
        check("single_rvalid_end", 256'(rvalid), 256'(0));
        check("single_busy_clr", 256'(tag_busy), 256'(0));

        // Split completion: 2 + 4 beats, rlast only on the sixth
        alloc(4'd1, 4'd9, 9'd6);
        clear_q();
        send_cpl(8'd1, 3'b000, 10'd16, 8'h10);
        drain(2, 1'b0);
        check("split_gap_rvalid", 256'(rvalid), 256'(0));
        check("split_gap_busy", 256'(tag_busy), 256'(16'h0002));
        send_cpl(8'd1, 3'b000, 10'd32, 8'h20);
        drain(6, 1'b0);
        verify(0, 256'(8'h10), 4'd9, 2'b00, 1'b0);
        verify(1, 256'(8'h11), 4'd9, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++)
            verify(i + 2, 256'(8'h20 + 8'(i)), 4'd9, 2'b00, i == 3);
        check("split_busy_clr", 256'(tag_busy), 256'(0));

        // Backpressure with rready 1,0,0,1,0,1,1
        alloc(4'd4, 4'd2, 9'd4);
        clear_q();
        send_cpl(8'd4, 3'b000, 10'd32, 8'h40);
        drain(4, 1'b1);
        for (int i = 0; i < 4; i++)
            verify(i, 256'(8'h40 + 8'(i)), 4'd2, 2'b00, i == 3);
        check("bp_rvalid_end", 256'(rvalid), 256'(0));
        check("bp_busy_clr", 256'(tag_busy), 256'(0));

        // Error status terminates the whole remaining burst
        alloc(4'd2, 4'd6, 9'd3);
        clear_q();
        send_cpl(8'd2, 3'b001, 10'd0, 8'h55);
        drain(3, 1'b0);
        for (int i = 0; i < 3; i++)
            verify(i, 256'(0), 4'd6, 2'b10, i == 2);
        check("err_rvalid_end", 256'(rvalid), 256'(0));
        check("err_busy_clr", 256'(tag_busy), 256'(0));

        // Unexpected completion on an unallocated tag
        send_cpl(8'd7, 3'b000, 10'd8, 8'h70);
        check("unexp_pulse", 256'(err_unexp_cpl), 256'(1));
        check("unexp_rvalid", 256'(rvalid), 256'(0));
        check("unexp_ready", 256'(cpl_ready), 256'(1));
        @(negedge clk);
        check("unexp_pulse_end", 256'(err_unexp_cpl), 256'(0));

        // Out-of-range tag
        send_cpl(8'd200, 3'b000, 10'd8, 8'h70);
        check("range_pulse", 256'(err_unexp_cpl), 256'(1));
        check("range_rvalid", 256'(rvalid), 256'(0));

        // Busy allocation keeps the first id
        alloc(4'd3, 4'd5, 9'd2);
        check("busy_first_ok", 256'(err_tag_busy), 256'(0));
        alloc(4'd3, 4'd11, 9'd2);
        check("busy_second_err", 256'(err_tag_busy), 256'(1));
        @(negedge clk);
        check("busy_pulse_end", 256'(err_tag_busy), 256'(0));

        // Oversize and zero-length SC on a live tag are dropped, table untouched
        send_cpl(8'd3, 3'b000, 10'd40, 8'h30);
        check("oversize_pulse", 256'(err_unexp_cpl), 256'(1));
        send_cpl(8'd3, 3'b000, 10'd0, 8'h30);
        check("zerolen_pulse", 256'(err_unexp_cpl), 256'(1));
        check("unexp_busy_kept", 256'(tag_busy), 256'(16'h0008));

        clear_q();
        send_cpl(8'd3, 3'b000, 10'd8, 8'h77);
        drain(1, 1'b0);
        verify(0, 256'(8'h77), 4'd5, 2'b00, 1'b0);
        check("busy_partial_kept", 256'(tag_busy), 256'(16'h0008));

        // Reset after two of four beats
        alloc(4'd5, 4'd3, 9'd4);
        clear_q();
        send_cpl(8'd5, 3'b000, 10'd32, 8'hC0);
        drain(2, 1'b0);
        verify(0, 256'(8'hC0), 4'd3, 2'b00, 1'b0);
        verify(1, 256'(8'hC1), 4'd3, 2'b00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", 256'(rvalid), 256'(0));
        check("midrst_busy", 256'(tag_busy), 256'(0));
        check("midrst_ready", 256'(cpl_ready), 256'(1));
        rst_n = 1'b1;
        @(negedge clk);

        alloc(4'd5, 4'd3, 9'd2);
        clear_q();
        send_cpl(8'd5, 3'b000, 10'd16, 8'hD0);
        drain(2, 1'b0);
        verify(0, 256'(8'hD0), 4'd3, 2'b00, 1'b0);
        verify(1, 256'(8'hD1), 4'd3, 2'b00, 1'b1);
        check("post_rst_busy_clr", 256'(tag_busy), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
